// File: rtl/scan_chain_driver.sv
// Scan chain driver: loads a pattern, optionally pulses one functional capture,
// then unloads the chain tail into CAP_OUT and compares it to an expected vector.
module scan_chain_driver #(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 CAP_EN,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] CAP_OUT,
  output logic                 MISMATCH
);

  localparam int unsigned IDX_W = $clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE_ST
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] exp_q;
  logic                 cap_en_q;

  logic [IDX_W-1:0]     si_idx_c;
  logic [IDX_W-1:0]     cap_idx_c;
  logic [CHAIN_LEN-1:0] cap_next_c;

  // SI for the next shift-in cycle and CAP_OUT after the current unload edge
  always_comb begin
    si_idx_c   = IDX_W'(CHAIN_LEN - 2) - IDX_W'(cnt);
    cap_idx_c  = IDX_W'(CHAIN_LEN - 1) - IDX_W'(cnt);
    cap_next_c = CAP_OUT;
    cap_next_c[cap_idx_c] = SO;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      pat_q    <= '0;
      exp_q    <= '0;
      cap_en_q <= 1'b0;
      SE       <= 1'b0;
      SI       <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      CAP_OUT  <= '0;
      MISMATCH <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          SE <= 1'b0;
          SI <= 1'b0;
          if (START) begin
            pat_q    <= PAT_IN;
            exp_q    <= EXP_IN;
            cap_en_q <= CAP_EN;
            cnt      <= '0;
            MISMATCH <= 1'b0;
            BUSY     <= 1'b1;
            SE       <= 1'b1;
            SI       <= PAT_IN[CHAIN_LEN-1];
            state    <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (cnt == LAST) begin
            cnt <= '0;
            SI  <= 1'b0;
            if (cap_en_q) begin
              SE    <= 1'b0;
              state <= CAPTURE;
            end else begin
              SE    <= 1'b1;
              state <= SHIFT_OUT;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            SI  <= pat_q[si_idx_c];
          end
        end
        CAPTURE: begin
          SE    <= 1'b1;
          SI    <= 1'b0;
          cnt   <= '0;
          state <= SHIFT_OUT;
        end
        SHIFT_OUT: begin
          CAP_OUT <= cap_next_c;
          if (cnt == LAST) begin
            cnt      <= '0;
            SE       <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            MISMATCH <= |(cap_next_c ^ exp_q);
            state    <= DONE_ST;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE_ST: begin
          SE    <= 1'b0;
          SI    <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          SE    <= 1'b0;
          SI    <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Self-checking bench for scan_chain_driver with a behavioural scan chain model.
module tb_scan_chain_driver;

  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = $clog2(N) + 1;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic         CAP_EN;
  logic [N-1:0] PAT_IN;
  logic [N-1:0] EXP_IN;
  logic         SO;
  logic         SE;
  logic         SI;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] CAP_OUT;
  logic         MISMATCH;

  scan_chain_driver #(.CHAIN_LEN(N), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CAP_EN(CAP_EN),
    .PAT_IN(PAT_IN), .EXP_IN(EXP_IN), .SO(SO),
    .SE(SE), .SI(SI), .BUSY(BUSY), .DONE(DONE),
    .CAP_OUT(CAP_OUT), .MISMATCH(MISMATCH)
  );

  always #5 CLK = ~CLK;

  // Chain model: shift when SE, otherwise load functional D (Q or ~Q)
  logic [N-1:0] chain = '0;
  logic         d_inv = 1'b0;
  always_ff @(posedge CLK) begin
    if (SE) chain <= {chain[N-2:0], SI};
    else    chain <= d_inv ? ~chain : chain;
  end
  assign SO = chain[N-1];

  typedef struct {
    logic         cap_en;
    logic [N-1:0] pat;
    logic [N-1:0] expv;
    logic         d_inv;
    logic [N-1:0] cap;
    logic         mis;
    int           lat;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];

  int           checks = 0;
  int           passed = 0;
  int           cyc;
  int           ndone;
  logic [N-1:0] si_seq;
  vec_t         v1, v2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_run(input vec_t v);
    CAP_EN = v.cap_en;
    PAT_IN = v.pat;
    EXP_IN = v.expv;
    d_inv  = v.d_inv;
    START  = 1'b1;
    sb.push_back(v);
    tick();
    cyc    = 1;
    START  = 1'b0;
    PAT_IN = N'($urandom);
    EXP_IN = N'($urandom);
    CAP_EN = 1'($urandom);
    chk("busy_set", 32'(BUSY), 32'd1);
    chk("se_shift_in", 32'(SE), 32'd1);
  endtask

  task automatic check_done();
    vec_t v;
    if (sb.size() == 0) begin
      chk("sb_empty_at_done", 32'(sb.size()), 32'd1);
    end else begin
      v = sb.pop_front();
      chk("cap_out", 32'(CAP_OUT), 32'(v.cap));
      chk("mismatch", 32'(MISMATCH), 32'(v.mis));
      chk("latency", 32'(cyc), 32'(v.lat));
    end
  endtask

  task automatic finish_run(input vec_t v);
    si_seq[N-1] = SI;
    for (int k = 1; k < N; k++) begin
      tick();
      cyc++;
      si_seq[N-1-k] = SI;
    end
    chk("si_seq", 32'(si_seq), 32'(v.pat));
    while (!DONE && cyc < 100) begin
      tick();
      cyc++;
    end
    if (DONE) begin
      check_done();
    end else begin
      chk("done_timeout", 32'(DONE), 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    chk("busy_in_done", 32'(BUSY), 32'd0);
    chk("se_in_done", 32'(SE), 32'd0);
    tick();
    cyc++;
    chk("done_pulse", 32'(DONE), 32'd0);
    chk("cap_held", 32'(CAP_OUT), 32'(v.cap));
    chk("mis_held", 32'(MISMATCH), 32'(v.mis));
  endtask

  initial begin
    vecs[0] = '{cap_en:1'b0, pat:8'hA5, expv:8'hA5, d_inv:1'b0, cap:8'hA5, mis:1'b0, lat:17};
    vecs[1] = '{cap_en:1'b1, pat:8'h3C, expv:8'hC3, d_inv:1'b1, cap:8'hC3, mis:1'b0, lat:18};
    vecs[2] = '{cap_en:1'b1, pat:8'h3C, expv:8'hC2, d_inv:1'b1, cap:8'hC3, mis:1'b1, lat:18};
    vecs[3] = '{cap_en:1'b0, pat:8'h5A, expv:8'h00, d_inv:1'b0, cap:8'h5A, mis:1'b1, lat:17};
    vecs[4] = '{cap_en:1'b1, pat:8'h81, expv:8'h81, d_inv:1'b0, cap:8'h81, mis:1'b0, lat:18};
    vecs[5] = '{cap_en:1'b1, pat:8'h00, expv:8'hFF, d_inv:1'b1, cap:8'hFF, mis:1'b0, lat:18};

    RST = 1'b1; START = 1'b0; CAP_EN = 1'b0; PAT_IN = '0; EXP_IN = '0;
    tick();
    tick();
    chk("rst_se", 32'(SE), 32'd0);
    chk("rst_si", 32'(SI), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_cap", 32'(CAP_OUT), 32'd0);
    chk("rst_mis", 32'(MISMATCH), 32'd0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      start_run(vecs[i]);
      finish_run(vecs[i]);
      tick();
    end

    // Abort in SHIFT_IN cycle 4, then a clean flush run
    start_run(vecs[0]);
    repeat (4) tick();
    RST = 1'b1;
    tick();
    void'(sb.pop_back());
    chk("abort_se", 32'(SE), 32'd0);
    chk("abort_si", 32'(SI), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_cap", 32'(CAP_OUT), 32'd0);
    chk("abort_mis", 32'(MISMATCH), 32'd0);
    RST = 1'b0;
    tick();
    chk("abort_idle_busy", 32'(BUSY), 32'd0);
    start_run(vecs[0]);
    finish_run(vecs[0]);
    tick();

    // START while busy / in DONE_ST is ignored; START right after DONE is taken
    v1 = vecs[0];
    v2 = vecs[2];
    ndone = 0;
    start_run(v1);
    while (cyc < 18) begin
      START = (cyc == 10 || cyc == 12 || cyc == 16 || cyc == 17);
      if (cyc == 17) begin
        CAP_EN = v2.cap_en;
        PAT_IN = v2.pat;
        EXP_IN = v2.expv;
      end
      tick();
      cyc++;
      if (DONE) begin
        ndone++;
        check_done();
      end
    end
    chk("busy_start_one_done", 32'(ndone), 32'd1);
    chk("busy_start_ignored", 32'(BUSY), 32'd0);
    start_run(v2);
    finish_run(v2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
